// File: rtl/prbs_stream_checker.sv
// prbs_stream_checker: packs bytes into 32-bit words and checks them against an expected word; `PRBS_CHK_BITERR_EN adds bit_err_count
module prbs_stream_checker #(
  parameter int ERR_CNT_W   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          exp_word,
  input  logic [7:0]           n_words,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [ERR_CNT_W-1:0] err_count,
`ifdef PRBS_CHK_BITERR_EN
  output logic [ERR_CNT_W-1:0] bit_err_count,
`endif
  output logic [7:0]           words_checked
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int IW = $clog2(TIMEOUT_CYC);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  state_t               state_q, state_d;
  logic [31:0]          exp_q, exp_d, word;
  logic [7:0]           n_q, n_d, words_q, words_d;
  logic [23:0]          sr_q, sr_d;
  logic [1:0]           idx_q, idx_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 timeout_q, timeout_d;
`ifdef PRBS_CHK_BITERR_EN
  localparam int BW = ERR_CNT_W + 6;
  logic [ERR_CNT_W-1:0] bit_q, bit_d;
  logic [BW-1:0]        bit_sum;
  assign bit_sum = BW'(bit_q) + BW'($countones(word ^ exp_q));
  assign bit_err_count = bit_q;
`endif
  assign word          = {sr_q, byte_in};
  assign busy          = state_q == RUN;
  assign done          = state_q == DONE;
  assign pass          = done && err_q == '0 && !timeout_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;
  assign words_checked = words_q;
  // Next state: accepted start re-arms, RUN packs/compares bytes or counts idle cycles
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    n_d       = n_q;
    sr_d      = sr_q;
    idx_d     = idx_q;
    idle_d    = idle_q;
    err_d     = err_q;
    words_d   = words_q;
    timeout_d = timeout_q;
`ifdef PRBS_CHK_BITERR_EN
    bit_d     = bit_q;
`endif
    if (start && state_q != RUN) begin
      state_d   = n_words != 8'd0 ? RUN : DONE;
      exp_d     = exp_word;
      n_d       = n_words;
      sr_d      = '0;
      idx_d     = '0;
      idle_d    = '0;
      err_d     = '0;
      words_d   = '0;
      timeout_d = 1'b0;
`ifdef PRBS_CHK_BITERR_EN
      bit_d     = '0;
`endif
    end else if (state_q == RUN && byte_valid) begin
      sr_d   = {sr_q[15:0], byte_in};
      idx_d  = idx_q + 2'd1;
      idle_d = '0;
      if (idx_q == 2'd3) begin
        err_d   = (word != exp_q && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;
        words_d = words_q + 8'd1;
        state_d = words_d == n_q ? DONE : RUN;
`ifdef PRBS_CHK_BITERR_EN
        bit_d   = bit_sum > BW'(ERR_MAX) ? ERR_MAX : bit_sum[ERR_CNT_W-1:0];
`endif
      end
    end else if (state_q == RUN) begin
      idle_d    = idle_q + 1'b1;
      timeout_d = idle_d == IW'(TIMEOUT_CYC - 1);
      state_d   = timeout_d ? DONE : RUN;
    end
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      n_q       <= '0;
      sr_q      <= '0;
      idx_q     <= '0;
      idle_q    <= '0;
      err_q     <= '0;
      words_q   <= '0;
      timeout_q <= 1'b0;
`ifdef PRBS_CHK_BITERR_EN
      bit_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      n_q       <= n_d;
      sr_q      <= sr_d;
      idx_q     <= idx_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      words_q   <= words_d;
      timeout_q <= timeout_d;
`ifdef PRBS_CHK_BITERR_EN
      bit_q     <= bit_d;
`endif
    end
  end
endmodule

// File: tb/tb_prbs_stream_checker.sv
// tb_prbs_stream_checker: directed checks of packing, compare, timeout, zero-length, ignored start, reset and saturation
module tb_prbs_stream_checker;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [31:0] exp_word = '0;
  logic [7:0] n_words = '0, byte_in = '0;
  logic busy, done, pass, timeout, busy2, done2, pass2, timeout2;
  logic [15:0] err_count;
  logic [1:0] err2;
  logic [7:0] words_checked, words2;
`ifdef PRBS_CHK_BITERR_EN
  logic [15:0] bit_err_count;
  logic [1:0] bit_err2;
`endif
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  prbs_stream_checker #(.ERR_CNT_W(16), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_word(exp_word), .n_words(n_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count),
`ifdef PRBS_CHK_BITERR_EN
    .bit_err_count(bit_err_count),
`endif
    .words_checked(words_checked));

  prbs_stream_checker #(.ERR_CNT_W(2), .TIMEOUT_CYC(16)) dut2 (
    .clk(clk), .rst(rst), .start(start), .exp_word(exp_word), .n_words(n_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .busy(busy2), .done(done2), .pass(pass2),
    .timeout(timeout2), .err_count(err2),
`ifdef PRBS_CHK_BITERR_EN
    .bit_err_count(bit_err2),
`endif
    .words_checked(words2));

  task automatic tick(input logic s, input logic v, input logic [7:0] b);
    start = s;
    byte_valid = v;
    byte_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [31:0] e, input logic [7:0] n);
    exp_word = e;
    n_words = n;
    tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) tick(1'b0, 1'b1, w[i*8 +: 8]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    n_chk++;
    if ({busy, done, pass, timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000", {busy, done, pass, timeout});
    end
    n_chk++;
    if (err_count !== 16'd0 || words_checked !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_counts got err=%0d words=%0d want 0 0", err_count, words_checked);
    end
  endtask

  task automatic test_match;
    arm(32'hAABBCCDD, 8'd2);
    n_chk++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL match_busy got busy,done=%b want 10", {busy, done});
    end
    send_word(32'hAABBCCDD);
    tick(1'b0, 1'b1, 8'hAA);
    tick(1'b0, 1'b1, 8'hBB);
    tick(1'b0, 1'b1, 8'hCC);
    n_chk++;
    if ({busy, done} !== 2'b10 || words_checked !== 8'd1) begin
      n_fail++;
      $display("FAIL match_before_last got busy,done=%b words=%0d want 10 1", {busy, done}, words_checked);
    end
    tick(1'b0, 1'b1, 8'hDD);
    n_chk++;
    if ({busy, done, pass, timeout} !== 4'b0110) begin
      n_fail++;
      $display("FAIL match_done got %b want 0110", {busy, done, pass, timeout});
    end
    n_chk++;
    if (err_count !== 16'd0 || words_checked !== 8'd2) begin
      n_fail++;
      $display("FAIL match_counts got err=%0d words=%0d want 0 2", err_count, words_checked);
    end
`ifdef PRBS_CHK_BITERR_EN
    n_chk++;
    if (bit_err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL match_biterr got %0d want 0", bit_err_count);
    end
`endif
  endtask

  task automatic test_mismatch;
    arm(32'hAABBCCDD, 8'd2);
    n_chk++;
    if ({busy, done, pass} !== 3'b100 || words_checked !== 8'd0) begin
      n_fail++;
      $display("FAIL mismatch_rearm got %b words=%0d want 100 0", {busy, done, pass}, words_checked);
    end
    send_word(32'hAABBCCDD);
    send_word(32'hAABBCCDC);
    n_chk++;
    if ({done, pass} !== 2'b10 || err_count !== 16'd1 || words_checked !== 8'd2) begin
      n_fail++;
      $display("FAIL mismatch_result got done,pass=%b err=%0d words=%0d want 10 1 2", {done, pass}, err_count, words_checked);
    end
`ifdef PRBS_CHK_BITERR_EN
    n_chk++;
    if (bit_err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL mismatch_biterr got %0d want 1", bit_err_count);
    end
`endif
  endtask

  task automatic test_timeout;
    arm(32'hAABBCCDD, 8'd3);
    n_chk++;
    if (err_count !== 16'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_rearm got err=%0d busy=%b want 0 1", err_count, busy);
    end
    send_word(32'hAABBCCDD);
    tick(1'b0, 1'b1, 8'hAA);
    for (int i = 0; i < 14; i++) tick(1'b0, 1'b0, 8'h00);
    n_chk++;
    if ({busy, done, timeout} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_early got busy,done,timeout=%b want 100", {busy, done, timeout});
    end
    tick(1'b0, 1'b0, 8'h00);
    n_chk++;
    if ({busy, done, pass, timeout} !== 4'b0101 || words_checked !== 8'd1 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL timeout_fire got %b words=%0d err=%0d want 0101 1 0", {busy, done, pass, timeout}, words_checked, err_count);
    end
  endtask

  task automatic test_zero;
    arm(32'h12345678, 8'd0);
    n_chk++;
    if ({busy, done, pass, timeout} !== 4'b0110 || words_checked !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_done got %b words=%0d want 0110 0", {busy, done, pass, timeout}, words_checked);
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'h00);
    n_chk++;
    if ({busy, done, pass} !== 3'b011 || words_checked !== 8'd0 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL zero_ignore got %b words=%0d err=%0d want 011 0 0", {busy, done, pass}, words_checked, err_count);
    end
  endtask

  task automatic test_start_mid;
    exp_word = 32'h11223344;
    n_words = 8'd1;
    tick(1'b1, 1'b1, 8'h99);
    tick(1'b0, 1'b1, 8'h11);
    tick(1'b0, 1'b1, 8'h22);
    exp_word = 32'h00000000;
    n_words = 8'd5;
    tick(1'b1, 1'b1, 8'h33);
    n_chk++;
    if ({busy, done} !== 2'b10 || words_checked !== 8'd0) begin
      n_fail++;
      $display("FAIL startmid_run got busy,done=%b words=%0d want 10 0", {busy, done}, words_checked);
    end
    tick(1'b0, 1'b1, 8'h44);
    n_chk++;
    if ({busy, done, pass} !== 3'b011 || words_checked !== 8'd1 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL startmid_done got %b words=%0d err=%0d want 011 1 0", {busy, done, pass}, words_checked, err_count);
    end
    arm(32'hAABBCCDD, 8'd2);
    send_word(32'h0000AABB);
    send_word(32'hFFFFFFFF);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 8'h00);
    rst = 1'b1;
    tick(1'b0, 1'b1, 8'h00);
    rst = 1'b0;
    n_chk++;
    if ({busy, done, pass, timeout} !== 4'b0000 || err_count !== 16'd0 || words_checked !== 8'd0) begin
      n_fail++;
      $display("FAIL midrun_rst got %b err=%0d words=%0d want 0000 0 0", {busy, done, pass, timeout}, err_count, words_checked);
    end
  endtask

  task automatic test_saturate;
    arm(32'h00000000, 8'd5);
    for (int w = 0; w < 4; w++) send_word(32'hFFFFFFFF);
    n_chk++;
    if (err2 !== 2'd3 || words2 !== 8'd4 || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_mid got err=%0d words=%0d busy=%b want 3 4 1", err2, words2, busy2);
    end
    send_word(32'hFFFFFFFF);
    n_chk++;
    if (err2 !== 2'd3 || words2 !== 8'd5 || {done2, pass2} !== 2'b10) begin
      n_fail++;
      $display("FAIL sat_end got err=%0d words=%0d done,pass=%b want 3 5 10", err2, words2, {done2, pass2});
    end
    n_chk++;
    if (err_count !== 16'd5) begin
      n_fail++;
      $display("FAIL sat_wide got err=%0d want 5", err_count);
    end
`ifdef PRBS_CHK_BITERR_EN
    n_chk++;
    if (bit_err_count !== 16'd160 || bit_err2 !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_biterr got %0d/%0d want 160/3", bit_err_count, bit_err2);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_match;
    test_mismatch;
    test_timeout;
    test_zero;
    test_start_mid;
    test_saturate;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
